rect_copy_controller: RTL
=========================

Name: rect_copy_controller

Overview:
- Transmit side of the rect-copy stream into gpu_receiver_fsm.
- Each frame: reads the 64-rect table from rect memory in 4 batches of 16 rects.
- Per batch, runs five phases (X, WIDTH, Y, HEIGHT, COLOR). Each phase loads 16 values, then drives a coordinate sweep so the receiver can build collision masks and colour entries.
- Sits between rect memory and the GPU receiver; started once per frame by `start`.

Parameters:
- RECT_BASE, 16'd0: word address of rect 0 in rect memory.
- SCREEN_WIDTH, 640: X sweep length, must be ≤1023.
- SCREEN_HEIGHT, 480: Y sweep length, must be ≤1023.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  spike: begin frame (ignored while busy)
- busy  out  1  high from the cycle after an accepted start until return to WAIT_FOR_START
- done  out  1  one-cycle spike on the final COLOR sweep beat of batch 3
- rect_mem_addr  out  16  rect memory read address; memory returns data 1 cycle later
- rect_mem_dout  in  16  rect memory read data
- dout  out  16  data stream to receiver din
- state  out  3  phase: 0 WAIT_FOR_START, 1 READ_X, 2 READ_WIDTH, 3 READ_Y, 4 READ_HEIGHT, 5 READ_COLOR
- coord_generator  out  10  sweep coordinate
- rect_counter  out  4  rect index within batch
- batch_counter  out  2  batch index
- batch_completed  out  1  0 = load/gap beat, 1 = sweep beat

Behaviour:
- Reset values:
  - All outputs 0; state = WAIT_FOR_START.
  - Internal x/y latches and pipeline cleared.
  - Reset mid-frame aborts immediately; there is no done spike.
- Beat sequence per phase; one beat per clock, all control outputs registered:
  - LOAD, 16 beats: batch_completed=0, rect_counter 0..15, coord_generator=0.
  - GAP, 2 beats: batch_completed=0, rect_counter held at 15. dout repeats the rect-15 value, so the rewrite is idempotent. The gap guarantees buffer writes are visible before the first sweep compare.
  - SWEEP: batch_completed=1, rect_counter=15, coord_generator 0..N-1.
    - N = SCREEN_WIDTH for X and WIDTH.
    - N = SCREEN_HEIGHT for Y and HEIGHT.
    - N = 16 for COLOR.
- Phase order per batch: X → WIDTH → Y → HEIGHT → COLOR.
- After COLOR, batch_counter increments. After batch 3 COLOR: state goes to WAIT_FOR_START, batch_counter wraps to 0, busy drops.
- start in WAIT_FOR_START: the next cycle is X LOAD beat 0 of batch 0.
- Frame length: start accepted to return to WAIT = 4×(2×(18+SCREEN_WIDTH) + 2×(18+SCREEN_HEIGHT) + 34) beats, i.e. 9384 at default.
- Memory reads, LOAD beats only:
  - rect_mem_addr = RECT_BASE + 5×(16×batch + rc) + field.
  - field offsets: X=0, Y=1, WIDTH=2, HEIGHT=3, COLOR=4.
  - Otherwise rect_mem_addr holds its last value.
- dout latency: dout for a beat appears exactly 3 cycles after that beat's control outputs (memory +1, compute register +1, output register +1). Receiver delay lines depend on this.
- Arithmetic; all fields are signed 16-bit:
  - X/Y LOAD: latch raw x (or y) per rect into a 16-entry internal register file. Emit left = 0 if v<0; 10'h3FF if v>S-1; else v. S is the screen dimension.
  - WIDTH/HEIGHT LOAD: r = latched v + size − 1, in 17-bit signed. Emit 0 if r<0 or size≤0; S−1 if r>S−1; else r.
  - dout[15:10] = 0 in coordinate phases.
  - COLOR LOAD: emit rect_mem_dout unchanged.
- Known limitation: a rect fully off the left/top edge may still hit pixel 0 if the receiver compare is inclusive. Software must cull such rects.
- Boundary conditions:
  - start while busy is ignored.
  - start in the same cycle as reset: reset wins.
  - coord_generator never exceeds N−1.
  - dout keeps producing the pipeline tail for 3 cycles after the last beat, then holds 0 in WAIT.

Test Plan:
- Reset, then start: cycle+1 shows state=1, rc=0, bc=0, batch_completed=0, rect_mem_addr=RECT_BASE. busy stays high for exactly 9384 cycles. done pulses once, on the final COLOR sweep beat (coord=15) of batch 3.
- Rect 0 = {x=100, y=50, w=20, h=10, color=16'hF800}: dout = 100 at X beat 0+3, 119 in WIDTH, 50 in Y, 59 in HEIGHT, 16'hF800 in COLOR.
- Rect 5 = {x=−30, w=50}: X emits 0, WIDTH emits 19. Rect 6 = {x=700, w=10}: X emits 10'h3FF. Rect 7 = {x=630, w=40}: WIDTH emits 639.
- Batch 2, rect 3, COLOR load: rect_mem_addr = RECT_BASE + 5×35 + 4 = RECT_BASE + 179.
- Phase shape: X sweep coord runs 0..639 then state=2 LOAD; Y sweep ends at 479. The GAP beats show batch_completed=0, rc=15, and dout equal to the rect-15 value.
- Assert reset during batch 1 HEIGHT sweep: next cycle all outputs are 0, no done pulse. A following start restarts at batch 0 X.

Source files
------------

// File: rtl/rect_copy_controller.sv
// rect_copy_controller: streams the 64-rect table to the GPU receiver as load beats followed by coordinate sweeps.
module rect_copy_controller #(
    parameter logic [15:0] RECT_BASE = 16'd0,
    parameter int SCREEN_WIDTH = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] rect_mem_addr,
    input  logic [15:0] rect_mem_dout,
    output logic [15:0] dout,
    output logic [2:0]  state,
    output logic [9:0]  coord_generator,
    output logic [3:0]  rect_counter,
    output logic [1:0]  batch_counter,
    output logic        batch_completed
);
    localparam logic [2:0] S_WAIT = 3'd0, S_X = 3'd1, S_W = 3'd2, S_Y = 3'd3, S_H = 3'd4, S_C = 3'd5;
    localparam logic [1:0] ST_LOAD = 2'd0, ST_SWEEP = 2'd3;
    localparam logic [9:0] W_LAST = 10'(SCREEN_WIDTH - 1), H_LAST = 10'(SCREEN_HEIGHT - 1);
    localparam logic signed [16:0] W_MAX = 17'(SCREEN_WIDTH - 1), H_MAX = 17'(SCREEN_HEIGHT - 1);

    logic [2:0]  r_state, w_n_state;
    logic [1:0]  r_stage, w_n_stage;
    logic [3:0]  r_rc, w_n_rc;
    logic [1:0]  r_bc, w_n_bc;
    logic [9:0]  r_coord, w_n_coord;
    logic [15:0] r_addr, w_n_addr;
    logic [9:0]  w_last;
    logic [15:0] w_field;

    assign w_last = (r_state == S_X || r_state == S_W) ? W_LAST :
                    (r_state == S_Y || r_state == S_H) ? H_LAST : 10'd15;
    assign w_field = w_n_state == S_X ? 16'd0 : w_n_state == S_W ? 16'd2 :
                     w_n_state == S_Y ? 16'd1 : w_n_state == S_H ? 16'd3 : 16'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_stage <= ST_LOAD;
            r_rc    <= '0;
            r_bc    <= '0;
            r_coord <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_n_state;
            r_stage <= w_n_stage;
            r_rc    <= w_n_rc;
            r_bc    <= w_n_bc;
            r_coord <= w_n_coord;
            r_addr  <= w_n_addr;
        end
    end

    // Stage walks LOAD -> GAP0 -> GAP1 -> SWEEP; rect counter parks at 15 through the gap and sweep.
    always_comb begin
        w_n_state = r_state;
        w_n_stage = r_stage;
        w_n_rc    = r_rc;
        w_n_bc    = r_bc;
        w_n_coord = r_coord;
        w_n_addr  = r_addr;
        if (r_state == S_WAIT) begin
            if (start) begin
                w_n_state = S_X;
                w_n_stage = ST_LOAD;
                w_n_rc    = '0;
                w_n_bc    = '0;
                w_n_coord = '0;
            end
        end else if (r_stage == ST_LOAD) begin
            if (r_rc == 4'd15) w_n_stage = r_stage + 2'd1;
            else w_n_rc = r_rc + 4'd1;
        end else if (r_stage != ST_SWEEP) begin
            w_n_stage = r_stage + 2'd1;
        end else if (r_coord != w_last) begin
            w_n_coord = r_coord + 10'd1;
        end else begin
            w_n_stage = ST_LOAD;
            w_n_rc    = '0;
            w_n_coord = '0;
            w_n_state = r_state == S_C ? (r_bc == 2'd3 ? S_WAIT : S_X) : r_state + 3'd1;
            w_n_bc    = r_state == S_C ? r_bc + 2'd1 : r_bc;
        end
        if (w_n_state != S_WAIT && w_n_stage == ST_LOAD)
            w_n_addr = RECT_BASE + 16'd5 * 16'({w_n_bc, w_n_rc}) + w_field;
    end

    logic [15:0] r_dout;

    always_comb begin
        state           = r_state;
        rect_counter    = r_rc;
        batch_counter   = r_bc;
        coord_generator = r_coord;
        rect_mem_addr   = r_addr;
        busy            = r_state != S_WAIT;
        batch_completed = r_stage == ST_SWEEP;
        done            = r_state == S_C && r_bc == 2'd3 && r_stage == ST_SWEEP && r_coord == 10'd15;
        dout            = r_dout;
    end

    // Stage p1 describes the beat whose memory word is on rect_mem_dout this cycle.
    logic [2:0]         r_p1_state;
    logic [3:0]         r_p1_rc;
    logic               r_p1_act;
    logic [15:0]        r_lat [16];
    logic [15:0]        r_comp;
    logic               w_p1_horiz, w_p1_pos;
    logic signed [16:0] w_v, w_lat, w_sum, w_max;
    logic [9:0]         w_left, w_right;
    logic [15:0]        w_comp;

    assign w_p1_horiz = r_p1_state == S_X || r_p1_state == S_W;
    assign w_p1_pos   = r_p1_state == S_X || r_p1_state == S_Y;
    assign w_max      = w_p1_horiz ? W_MAX : H_MAX;
    assign w_v        = {rect_mem_dout[15], rect_mem_dout};
    assign w_lat      = {r_lat[r_p1_rc][15], r_lat[r_p1_rc]};
    assign w_sum      = w_lat + w_v - 17'sd1;
    assign w_left     = w_v < 17'sd0 ? 10'd0 : w_v > w_max ? 10'h3FF : w_v[9:0];
    assign w_right    = (w_sum < 17'sd0 || w_v <= 17'sd0) ? 10'd0 : w_sum > w_max ? w_max[9:0] : w_sum[9:0];
    assign w_comp     = !r_p1_act ? 16'd0 : r_p1_state == S_C ? rect_mem_dout : {6'd0, w_p1_pos ? w_left : w_right};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p1_state <= S_WAIT;
            r_p1_rc    <= '0;
            r_p1_act   <= 1'b0;
            r_comp     <= '0;
            r_dout     <= '0;
            for (int i = 0; i < 16; i++) r_lat[i] <= '0;
        end else begin
            r_p1_state <= r_state;
            r_p1_rc    <= r_rc;
            r_p1_act   <= r_state != S_WAIT && r_stage != ST_SWEEP;
            r_comp     <= w_comp;
            r_dout     <= r_comp;
            if (r_p1_act && w_p1_pos) r_lat[r_p1_rc] <= rect_mem_dout;
        end
    end
endmodule
